// File: rtl/sha_farm_sched.sv
// rtl/sha_farm_sched.sv - loads nonces into a ROWSxCOLS hashing farm, polls for hits, repeats up to MAX_PASS passes.
// Define SHA_FARM_SCHED_CONTINUE_EN to keep polling after a hit; the job then ends only on pass exhaustion.
module sha_farm_sched #(
  parameter int WIDTH_ADD  = 5,
  parameter int WIDTH_FARM = 16,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int MAX_PASS   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  job_valid_i,
  input  logic [WIDTH_FARM-1:0] job_base_i,
  output logic                  job_ready_o,
  input  logic                  farmbusy_i,
  input  logic [WIDTH_FARM-1:0] farmrdata_i,
  output logic [WIDTH_ADD-1:0]  writerow_o,
  output logic [WIDTH_ADD-1:0]  writecol_o,
  output logic [WIDTH_ADD-1:0]  readrow_o,
  output logic [WIDTH_ADD-1:0]  readcol_o,
  output logic [WIDTH_FARM-1:0] farmwdata_o,
  output logic                  farmwrite_o,
  output logic                  farmread_o,
  output logic                  hit_valid_o,
  output logic [WIDTH_ADD-1:0]  hit_row_o,
  output logic [WIDTH_ADD-1:0]  hit_col_o,
  output logic [WIDTH_FARM-1:0] hit_data_o,
  output logic                  done_o,
  output logic                  exhausted_o
);

  localparam int UNITS  = ROWS * COLS;
  localparam int IDX_W  = (UNITS > 1) ? $clog2(UNITS) : 1;
  localparam int PASS_W = (MAX_PASS > 1) ? $clog2(MAX_PASS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, POLL, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [WIDTH_FARM-1:0] base;
  logic [IDX_W-1:0]      idx;
  logic [WIDTH_ADD-1:0]  row, col, pend_row, pend_col;
  logic [PASS_W-1:0]     pass;
  logic                  rd_pend, hit_job, exhausted_q;
  logic                  hit_now, last_unit, last_pass, stop_poll;

  // A read strobe in cycle t owes a sample of farmrdata_i in cycle t+1.
  assign hit_now   = rd_pend && farmrdata_i[WIDTH_FARM-1];
  assign last_unit = (32'(idx) == 32'(UNITS - 1));
  assign last_pass = ((32'(pass) + 32'd1) == 32'(MAX_PASS));

`ifdef SHA_FARM_SCHED_CONTINUE_EN
  assign stop_poll = 1'b0;
`else
  assign stop_poll = hit_now || hit_job;
`endif

  assign job_ready_o = (state == IDLE);
  assign done_o      = (state == DONE);
  assign exhausted_o = (state == DONE) && exhausted_q;
  assign writerow_o  = row;
  assign writecol_o  = col;
  assign readrow_o   = row;
  assign readcol_o   = col;
  assign farmwdata_o = base + WIDTH_FARM'(idx);

  always_comb begin
    state_nxt   = state;
    farmwrite_o = 1'b0;
    farmread_o  = 1'b0;
    case (state)
      IDLE:  if (job_valid_i) state_nxt = LOAD;
      LOAD: begin
        if (!farmbusy_i) begin
          farmwrite_o = 1'b1;
          if (last_unit) state_nxt = POLL;
        end
      end
      POLL: begin
        if (!farmbusy_i) begin
          if (stop_poll) begin
            state_nxt = DRAIN;
          end else begin
            farmread_o = 1'b1;
            if (last_unit) state_nxt = DRAIN;
          end
        end
      end
      DRAIN: state_nxt = (stop_poll || last_pass) ? DONE : LOAD;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      base        <= '0;
      idx         <= '0;
      row         <= '0;
      col         <= '0;
      pend_row    <= '0;
      pend_col    <= '0;
      pass        <= '0;
      rd_pend     <= 1'b0;
      hit_job     <= 1'b0;
      exhausted_q <= 1'b0;
      hit_valid_o <= 1'b0;
      hit_row_o   <= '0;
      hit_col_o   <= '0;
      hit_data_o  <= '0;
    end else begin
      state       <= state_nxt;
      rd_pend     <= farmread_o;
      hit_valid_o <= hit_now;
      if (farmread_o) begin
        pend_row <= row;
        pend_col <= col;
      end
      if (hit_now) begin
        hit_row_o  <= pend_row;
        hit_col_o  <= pend_col;
        hit_data_o <= farmrdata_i;
        hit_job    <= 1'b1;
      end
      if (farmwrite_o || farmread_o) begin
        if (last_unit) begin
          idx <= '0;
          row <= '0;
          col <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
          if (32'(col) == 32'(COLS - 1)) begin
            col <= '0;
            row <= row + WIDTH_ADD'(1);
          end else begin
            col <= col + WIDTH_ADD'(1);
          end
        end
      end
      case (state)
        IDLE: begin
          if (job_valid_i) begin
            base        <= job_base_i;
            pass        <= '0;
            idx         <= '0;
            row         <= '0;
            col         <= '0;
            hit_job     <= 1'b0;
            exhausted_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (state_nxt == DONE) begin
            exhausted_q <= !(hit_job || hit_now);
          end else begin
            base <= base + WIDTH_FARM'(UNITS);
            pass <= pass + PASS_W'(1);
            idx  <= '0;
            row  <= '0;
            col  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_farm_sched.sv
// tb/tb_sha_farm_sched.sv - directed bench for sha_farm_sched with ROWS=COLS=2, MAX_PASS=3.
module tb_sha_farm_sched;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        job_valid_i = 1'b0;
  logic [15:0] job_base_i = '0;
  logic        job_ready_o;
  logic        farmbusy_i = 1'b0;
  logic [15:0] farmrdata_i = '0;
  logic [4:0]  writerow_o, writecol_o, readrow_o, readcol_o;
  logic [15:0] farmwdata_o;
  logic        farmwrite_o, farmread_o;
  logic        hit_valid_o;
  logic [4:0]  hit_row_o, hit_col_o;
  logic [15:0] hit_data_o;
  logic        done_o, exhausted_o;

  sha_farm_sched #(
    .WIDTH_ADD(5), .WIDTH_FARM(16), .ROWS(2), .COLS(2), .MAX_PASS(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .job_valid_i(job_valid_i), .job_base_i(job_base_i), .job_ready_o(job_ready_o),
    .farmbusy_i(farmbusy_i), .farmrdata_i(farmrdata_i),
    .writerow_o(writerow_o), .writecol_o(writecol_o),
    .readrow_o(readrow_o), .readcol_o(readcol_o),
    .farmwdata_o(farmwdata_o), .farmwrite_o(farmwrite_o), .farmread_o(farmread_o),
    .hit_valid_o(hit_valid_o), .hit_row_o(hit_row_o), .hit_col_o(hit_col_o),
    .hit_data_o(hit_data_o), .done_o(done_o), .exhausted_o(exhausted_o)
  );

  always #5 clk_i = ~clk_i;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [15:0] wr_data_q[$];
  logic [9:0]  wr_addr_q[$];
  int          wr_cyc_q[$];
  logic [9:0]  rd_addr_q[$];
  logic [25:0] hit_q[$];
  int          done_cnt = 0;
  int          both_cnt = 0;
  logic        exh_at_done = 1'b0;
  logic [15:0] resp[4];
  logic        rd_pend = 1'b0;
  logic        rd_first = 1'b0;
  int          rd_unit = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (rst_i) begin
      rd_pend = 1'b0;
    end else begin
      if (farmwrite_o) begin
        wr_data_q.push_back(farmwdata_o);
        wr_addr_q.push_back({writerow_o, writecol_o});
        wr_cyc_q.push_back(cyc);
      end
      if (farmread_o) rd_addr_q.push_back({readrow_o, readcol_o});
      if (farmwrite_o && farmread_o) both_cnt++;
      if (hit_valid_o) hit_q.push_back({hit_row_o, hit_col_o, hit_data_o});
      if (done_o) begin
        done_cnt++;
        exh_at_done = exhausted_o;
      end
      rd_pend  = farmread_o;
      rd_unit  = int'(readrow_o) * 2 + int'(readcol_o);
      rd_first = (rd_addr_q.size() <= 4);
    end
  end

  // Farm model: only the first pass of a job returns programmed words.
  always @(posedge clk_i) begin
    #1;
    farmrdata_i = (rd_pend && rd_first) ? resp[rd_unit & 3] : 16'h0000;
  end

  task automatic clear_logs();
    wr_data_q.delete();
    wr_addr_q.delete();
    wr_cyc_q.delete();
    rd_addr_q.delete();
    hit_q.delete();
    done_cnt = 0;
    both_cnt = 0;
    exh_at_done = 1'b0;
    for (int k = 0; k < 4; k++) resp[k] = 16'h0000;
  endtask

  task automatic start_job(input logic [15:0] base);
    @(negedge clk_i);
    job_valid_i = 1'b1;
    job_base_i  = base;
    @(posedge clk_i);
    #1;
    job_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && done_cnt == 0; i++) @(negedge clk_i);
    check({tag, "_done_cnt"}, done_cnt, 1);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic check_writes(input string tag, input int n, input logic [15:0] base);
    logic [15:0] d;
    for (int k = 0; k < n; k++) begin
      d = base + 16'(k);
      check({tag, "_wdata"}, (k < wr_data_q.size()) ? 32'(wr_data_q[k]) : 32'hDEAD_BEEF, 32'(d));
      check({tag, "_waddr"}, (k < wr_addr_q.size()) ? 32'(wr_addr_q[k]) : 32'hDEAD_BEEF,
            32'({5'((k % 4) / 2), 5'(k % 2)}));
    end
  endtask

  task automatic check_reads(input string tag, input int n);
    for (int k = 0; k < n; k++)
      check({tag, "_raddr"}, (k < rd_addr_q.size()) ? 32'(rd_addr_q[k]) : 32'hDEAD_BEEF,
            32'({5'((k % 4) / 2), 5'(k % 2)}));
  endtask

  initial begin
    clear_logs();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Reset state
    check("rst_ready", job_ready_o, 1);
    check("rst_strobes", {farmwrite_o, farmread_o, hit_valid_o, done_o, exhausted_o}, 0);
    check("rst_addr", {writerow_o, writecol_o, readrow_o, readcol_o}, 0);
    check("rst_data", {farmwdata_o, hit_data_o}, 0);
    check("rst_hitaddr", {hit_row_o, hit_col_o}, 0);

    // No hits: three passes then exhaustion
    clear_logs();
    start_job(16'h0100);
    wait_done("nohit");
    check("nohit_wcount", wr_data_q.size(), 12);
    check("nohit_rcount", rd_addr_q.size(), 12);
    check_writes("nohit", 12, 16'h0100);
    check_reads("nohit", 12);
    check("nohit_exhausted", exh_at_done, 1);
    check("nohit_hits", hit_q.size(), 0);
    check("nohit_both", both_cnt, 0);

`ifndef SHA_FARM_SCHED_CONTINUE_EN
    // First hit ends the job
    clear_logs();
    resp[2] = 16'h8ABC;
    start_job(16'h0010);
    wait_done("hit");
    check("hit_wcount", wr_data_q.size(), 4);
    check_writes("hit", 4, 16'h0010);
    check("hit_rcount", rd_addr_q.size(), 3);
    check_reads("hit", 3);
    check("hit_count", hit_q.size(), 1);
    check("hit_word", (hit_q.size() > 0) ? 32'(hit_q[0]) : 32'hDEAD_BEEF, 32'({5'd1, 5'd0, 16'h8ABC}));
    check("hit_exhausted", exh_at_done, 0);
`else
    // Continue mode: hits do not end the job
    clear_logs();
    resp[1] = 16'h8001;
    resp[3] = 16'h8003;
    start_job(16'h0040);
    wait_done("cont");
    check("cont_wcount", wr_data_q.size(), 12);
    check("cont_rcount", rd_addr_q.size(), 12);
    check_writes("cont", 12, 16'h0040);
    check("cont_hits", hit_q.size(), 2);
    check("cont_hit0", (hit_q.size() > 0) ? 32'(hit_q[0]) : 32'hDEAD_BEEF, 32'({5'd0, 5'd1, 16'h8001}));
    check("cont_hit1", (hit_q.size() > 1) ? 32'(hit_q[1]) : 32'hDEAD_BEEF, 32'({5'd1, 5'd1, 16'h8003}));
    check("cont_exhausted", exh_at_done, 0);
`endif

    // Farm stall for 3 cycles while unit 2 is due
    clear_logs();
    start_job(16'h2000);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 farmbusy_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 farmbusy_i = 1'b0;
    wait_done("busy");
    check("busy_wcount", wr_data_q.size(), 12);
    check_writes("busy", 4, 16'h2000);
    check("busy_gap", (wr_cyc_q.size() > 2) ? 32'(wr_cyc_q[2] - wr_cyc_q[1]) : 32'hDEAD_BEEF, 4);
    check("busy_exhausted", exh_at_done, 1);

    // Nonce wrap, with a stray job offer during LOAD
    clear_logs();
    start_job(16'hFFFE);
    job_valid_i = 1'b1;
    job_base_i  = 16'h5555;
    repeat (5) @(negedge clk_i);
    job_valid_i = 1'b0;
    wait_done("wrap");
    check_writes("wrap", 5, 16'hFFFE);
    check("wrap_w3", (wr_data_q.size() > 3) ? 32'(wr_data_q[3]) : 32'hDEAD_BEEF, 32'h0001);

    // Reset during pass 2 poll abandons the job
    clear_logs();
    start_job(16'h0300);
    for (int i = 0; i < 300 && rd_addr_q.size() < 6; i++) @(negedge clk_i);
    check("rst_mid_reached", rd_addr_q.size(), 6);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_mid_ready", job_ready_o, 1);
    check("rst_mid_strobes", {farmwrite_o, farmread_o, hit_valid_o, done_o, exhausted_o}, 0);
    check("rst_mid_addr", {writerow_o, writecol_o, readrow_o, readcol_o}, 0);
    check("rst_mid_data", {farmwdata_o, hit_data_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (30) @(negedge clk_i);
    check("rst_mid_nodone", done_cnt, 0);
    check("rst_mid_wcount", wr_data_q.size(), 8);
    check("rst_mid_idle", job_ready_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sha_farm_sched.md
SHA_FARM_SCHED -- requirements
Module: sha_farm_sched

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- WIDTH_ADD, 5, width of the encoded row and column addresses.
- WIDTH_FARM, 16, width of the farm data word.
- ROWS, 4, number of populated farm rows.
- COLS, 4, number of populated farm columns.
- MAX_PASS, 8, number of load/poll passes per job before giving up.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, sole clock; all logic is on the rising edge.
- rst_i, in, 1, reset, synchronous, active-high.
- job_valid_i, in, 1, job offer.
- job_base_i, in, WIDTH_FARM, starting nonce of the job.
- job_ready_o, out, 1, high only in IDLE.
- farmbusy_i, in, 1, farm stall.
- farmrdata_i, in, WIDTH_FARM, read data, valid 1 cycle after the read strobe.
- writerow_o, out, WIDTH_ADD, write row address.
- writecol_o, out, WIDTH_ADD, write column address.
- readrow_o, out, WIDTH_ADD, read row address.
- readcol_o, out, WIDTH_ADD, read column address.
- farmwdata_o, out, WIDTH_FARM, write data.
- farmwrite_o, out, 1, write strobe.
- farmread_o, out, 1, read strobe.
- hit_valid_o, out, 1, 1-cycle hit pulse.
- hit_row_o, out, WIDTH_ADD, row of the unit that reported the hit.
- hit_col_o, out, WIDTH_ADD, column of the unit that reported the hit.
- hit_data_o, out, WIDTH_FARM, hit result word.
- done_o, out, 1, 1-cycle job-end pulse.
- exhausted_o, out, 1, qualifies done_o: the job ended with no hit.

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD, POLL, DRAIN and DONE.
REQ-004 In IDLE, a cycle with job_valid_i high (accepted because job_ready_o is high) SHALL latch job_base_i into base, clear the pass counter and unit index, and move to LOAD.
REQ-005 LOAD SHALL visit units in row-major order, index i = row*COLS + col, from 0 to ROWS*COLS-1.
REQ-006 In each LOAD cycle with farmbusy_i low, the block SHALL:
- assert farmwrite_o;
- drive writerow_o and writecol_o with the unit's row and column;
- drive farmwdata_o with (base + i) mod 2^WIDTH_FARM;
- advance the index by one.
REQ-007 After the LOAD write to unit ROWS*COLS-1, the block SHALL reset the index to 0 and move to POLL.
REQ-008 POLL SHALL visit units in the same order, asserting farmread_o with readrow_o and readcol_o for one unit per cycle in which farmbusy_i is low.
REQ-009 The block SHALL sample farmrdata_i in the cycle after each read strobe; a sampled word with MSB = 1 is a hit.
REQ-010 On a hit, the block SHALL pulse hit_valid_o in the cycle after sampling, with hit_row_o, hit_col_o and hit_data_o giving the unit's row, column and sampled word.
REQ-011 After the read of the last unit, the FSM SHALL go to DRAIN for exactly one cycle so that the final sample is evaluated.
REQ-012 At the end of DRAIN:
- If a hit occurred in this pass, the FSM SHALL move to DONE.
- Otherwise, if the pass count + 1 equals MAX_PASS, it SHALL move to DONE with exhausted_o set.
- Otherwise it SHALL add ROWS*COLS to base (mod 2^WIDTH_FARM), increment the pass count and return to LOAD.
REQ-013 DONE SHALL pulse done_o for one cycle, with exhausted_o valid in that same cycle, and then return to IDLE.
REQ-014 While farmbusy_i is high, farmwrite_o and farmread_o SHALL be low and the addresses, index and state SHALL hold.
- A sample already owed for a read issued in the previous cycle SHALL still be taken.
REQ-015 Nonce arithmetic SHALL wrap modulo 2^WIDTH_FARM; base 0xFFFE with unit index 3 writes 0x0001.
REQ-016 job_valid_i outside IDLE SHALL be ignored.
REQ-017 Write and read strobes SHALL never be asserted in the same cycle.

Reset
REQ-018 When rst_i is high at a rising edge, the FSM SHALL enter IDLE and all strobes and pulses SHALL be 0.
REQ-019 During reset, all address and data outputs, base, index and pass counter SHALL be 0, and job_ready_o SHALL be 1 from the first cycle after reset.
REQ-020 A reset in any state, mid-pass included, SHALL abandon the job with no done_o pulse.

Configuration
REQ-021 When macro SHA_FARM_SCHED_CONTINUE_EN is defined, a hit SHALL NOT end the job.
- POLL continues, and every hit pulses hit_valid_o.
- The job ends only on MAX_PASS exhaustion.
- exhausted_o is set in DONE only if zero hits occurred over the whole job.
REQ-022 When SHA_FARM_SCHED_CONTINUE_EN is undefined, the first hit SHALL end the job.
- POLL proceeds straight to DRAIN, then DONE; remaining units are not read.
- At most one hit_valid_o pulse occurs per job.

Verification (ROWS=COLS=2, MAX_PASS=3 unless stated)
REQ-023 Job base 0x0100, no hits -> writes 0x0100..0x0103, then 0x0104..0x0107, then 0x0108..0x010B; done_o pulses with exhausted_o=1; exactly 12 writes and 12 reads.
REQ-024 Base 0x0010, unit (1,0) returns 0x8ABC in pass 1 -> hit_valid_o pulses with row 1, col 0, data 0x8ABC; done_o pulses with exhausted_o=0; unit (1,1) is not read (macro undefined).
REQ-025 farmbusy_i high for 3 cycles during the LOAD of unit 2 -> the strobe is absent for 3 cycles; the unit 2 write of base+2 follows with the address unchanged; no unit is skipped.
REQ-026 Base 0xFFFE -> units write 0xFFFE, 0xFFFF, 0x0000 and 0x0001; pass 2 starts at 0x0002.
REQ-027 rst_i asserted during POLL of pass 2 -> in the next cycle all outputs are 0 and job_ready_o is 1; no done_o pulse.
REQ-028 With SHA_FARM_SCHED_CONTINUE_EN defined, units (0,1) and (1,1) hit in pass 1 -> two hit_valid_o pulses, all 3 passes run, done_o pulses with exhausted_o=0.
